// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline control for a 5-stage (IF/ID/EX/MEM/WB) CPU with no
//               forwarding network. Tracks the register writes still in
//               flight in EX, MEM and WB. It holds the PC and IF/ID and
//               inserts an ID/EX bubble when the instruction in ID reads a
//               register that is not yet written back. It flushes the
//               wrong-path instruction in IF/ID when EX takes a jump or
//               branch. Three saturating performance counters are included.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               id_rs1_addr/_used     - rs1 field and read-enable of ID instr
//               id_rs2_addr/_used     - rs2 field and read-enable of ID instr
//               id_rd_addr, id_rf_wen - destination and write-enable of ID
//               jump_flag             - ALU taken redirect for the EX instr
//               stall_pc              - hold PC and IF/ID
//               bubble_ex             - load NOP into ID/EX
//               flush_id              - clear IF/ID to NOP
//               jump_taken            - redirect qualified by EX slot valid
//               stall_cnt, flush_cnt, retire_cnt - saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int WB_BYPASS = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_rf_wen,
  input  logic             jump_flag,
  output logic             stall_pc,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             jump_taken,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  // With register-file write-through the WB producer is already visible to
  // ID, so the WB slot only takes part in the hazard check when it is off.
  localparam logic             c_WB_STALL = (WB_BYPASS == 0);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  logic       r_id_v;
  logic       r_v_ex,  r_w_ex;
  logic [4:0] r_rd_ex;
  logic       r_v_mem, r_w_mem;
  logic [4:0] r_rd_mem;
  logic       r_v_wb,  r_w_wb;
  logic [4:0] r_rd_wb;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_retire_cnt;

  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_hazard;
  logic w_jump;
  logic w_stall;
  logic w_bubble;
  logic w_flush;

  // The w_* slot flags are only ever set for rd != 0, so x0 cannot match.
  assign w_hit_rs1 = (r_w_ex  && (r_rd_ex  == id_rs1_addr)) ||
                     (r_w_mem && (r_rd_mem == id_rs1_addr)) ||
                     (c_WB_STALL && r_w_wb && (r_rd_wb == id_rs1_addr));
  assign w_hit_rs2 = (r_w_ex  && (r_rd_ex  == id_rs2_addr)) ||
                     (r_w_mem && (r_rd_mem == id_rs2_addr)) ||
                     (c_WB_STALL && r_w_wb && (r_rd_wb == id_rs2_addr));

  assign w_hazard = r_id_v &&
                    ((id_rs1_used && (id_rs1_addr != 5'd0) && w_hit_rs1) ||
                     (id_rs2_used && (id_rs2_addr != 5'd0) && w_hit_rs2));

  // A taken redirect squashes the ID instruction, so any hazard it had is moot.
  assign w_jump   = jump_flag && r_v_ex;
  assign w_flush  = w_jump;
  assign w_bubble = w_jump || w_hazard;
  assign w_stall  = !w_jump && w_hazard;

  assign stall_pc   = !reset && w_stall;
  assign bubble_ex  = !reset && w_bubble;
  assign flush_id   = !reset && w_flush;
  assign jump_taken = !reset && w_jump;

  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign retire_cnt = r_retire_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_v       <= 1'b0;
      r_v_ex       <= 1'b0;
      r_w_ex       <= 1'b0;
      r_rd_ex      <= 5'd0;
      r_v_mem      <= 1'b0;
      r_w_mem      <= 1'b0;
      r_rd_mem     <= 5'd0;
      r_v_wb       <= 1'b0;
      r_w_wb       <= 1'b0;
      r_rd_wb      <= 5'd0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_flush) begin
        r_id_v <= 1'b0;
      end else if (!w_stall) begin
        r_id_v <= 1'b1;
      end

      r_v_wb   <= r_v_mem;
      r_w_wb   <= r_w_mem;
      r_rd_wb  <= r_rd_mem;
      r_v_mem  <= r_v_ex;
      r_w_mem  <= r_w_ex;
      r_rd_mem <= r_rd_ex;

      if (w_bubble || !r_id_v) begin
        r_v_ex  <= 1'b0;
        r_w_ex  <= 1'b0;
        r_rd_ex <= 5'd0;
      end else begin
        r_v_ex  <= 1'b1;
        r_w_ex  <= id_rf_wen && (id_rd_addr != 5'd0);
        r_rd_ex <= id_rd_addr;
      end

      if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_jump && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (r_v_wb && (r_retire_cnt != c_CNT_MAX)) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Bench for hazard_ctrl. Two instances share one stimulus
//               stream: one with WB_BYPASS=0 and CNT_W=4, one with
//               WB_BYPASS=1 and CNT_W=8. The reference model tracks, for
//               each architectural register, how many cycles remain until
//               its newest pending write becomes visible to ID. It also
//               tracks the cycle in which each issued instruction retires.
//               Expected values go into one queue per instance and are
//               compared as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, wen, jf;

  logic       s0, b0, f0, j0;
  logic [3:0] sc0, fc0, rc0;
  logic       s1, b1, f1, j1;
  logic [7:0] sc1, fc1, rc1;

  always #5 clk = ~clk;

  hazard_ctrl #(.WB_BYPASS(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset),
    .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
    .id_rd_addr(rd), .id_rf_wen(wen), .jump_flag(jf),
    .stall_pc(s0), .bubble_ex(b0), .flush_id(f0), .jump_taken(j0),
    .stall_cnt(sc0), .flush_cnt(fc0), .retire_cnt(rc0)
  );

  hazard_ctrl #(.WB_BYPASS(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset),
    .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
    .id_rd_addr(rd), .id_rf_wen(wen), .jump_flag(jf),
    .stall_pc(s1), .bubble_ex(b1), .flush_id(f1), .jump_taken(j1),
    .stall_cnt(sc1), .flush_cnt(fc1), .retire_cnt(rc1)
  );

  typedef struct packed {
    logic        s, b, f, j;
    logic [31:0] sc, fc, rc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model state, index 0 = WB_BYPASS 0, index 1 = WB_BYPASS 1.
  int   m_pend [2][32];   // cycles until the newest write to reg is visible
  bit   m_idv  [2];
  bit   m_exv  [2];
  int   m_sc   [2];
  int   m_fc   [2];
  int   m_rc   [2];
  int   m_ret0 [$];       // cycle numbers in which an instruction sits in WB
  int   m_ret1 [$];

  function automatic exp_t model_eval(input int d);
    exp_t e;
    bit   jt, haz;
    e   = '0;
    jt  = jf && m_exv[d];
    haz = m_idv[d] &&
          ((u1 && rs1 != 0 && m_pend[d][rs1] > 0) ||
           (u2 && rs2 != 0 && m_pend[d][rs2] > 0));
    if (!reset) begin
      e.j = jt;
      e.f = jt;
      e.b = jt || haz;
      e.s = !jt && haz;
    end
    e.sc = m_sc[d];
    e.fc = m_fc[d];
    e.rc = m_rc[d];
    return e;
  endfunction

  task automatic model_adv(input int d, input exp_t e, input int maxv);
    bit enter;
    bit ret;
    if (reset) begin
      for (int r = 0; r < 32; r++) m_pend[d][r] = 0;
      m_idv[d] = 0; m_exv[d] = 0;
      m_sc[d] = 0; m_fc[d] = 0; m_rc[d] = 0;
      if (d == 0) m_ret0.delete(); else m_ret1.delete();
    end else begin
      if (e.s && m_sc[d] < maxv) m_sc[d]++;
      if (e.j && m_fc[d] < maxv) m_fc[d]++;
      ret = 0;
      if (d == 0) begin
        if (m_ret0.size() > 0 && m_ret0[0] == cyc) begin ret = 1; void'(m_ret0.pop_front()); end
      end else begin
        if (m_ret1.size() > 0 && m_ret1[0] == cyc) begin ret = 1; void'(m_ret1.pop_front()); end
      end
      if (ret && m_rc[d] < maxv) m_rc[d]++;
      for (int r = 0; r < 32; r++) if (m_pend[d][r] > 0) m_pend[d][r]--;
      enter = m_idv[d] && !e.b;
      if (enter) begin
        if (d == 0) m_ret0.push_back(cyc + 3); else m_ret1.push_back(cyc + 3);
        if (wen && rd != 0) m_pend[d][rd] = (d == 0) ? 3 : 2;
      end
      m_exv[d] = enter;
      m_idv[d] = e.f ? 1'b0 : (e.s ? m_idv[d] : 1'b1);
    end
  endtask

  task automatic step(input bit r, input int a1, input bit uu1, input int a2,
                      input bit uu2, input int d_rd, input bit w, input bit j);
    exp_t e0, e1;
    @(negedge clk);
    reset = r;
    rs1 = a1[4:0]; u1 = uu1; rs2 = a2[4:0]; u2 = uu2;
    rd = d_rd[4:0]; wen = w; jf = j;
    e0 = model_eval(0);
    e1 = model_eval(1);
    q0.push_back(e0);
    q1.push_back(e1);
    model_adv(0, e0, 15);
    model_adv(1, e1, 255);
    cyc++;
  endtask

  // Independent ADDI rd, x0, imm
  task automatic addi(input int d_rd);
    step(0, 0, 1, 0, 0, d_rd, 1, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are compared 1 time unit after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0 stall_pc",   {31'b0, s0},  {31'b0, e.s});
        chk("d0 bubble_ex",  {31'b0, b0},  {31'b0, e.b});
        chk("d0 flush_id",   {31'b0, f0},  {31'b0, e.f});
        chk("d0 jump_taken", {31'b0, j0},  {31'b0, e.j});
        chk("d0 stall_cnt",  {28'b0, sc0}, e.sc);
        chk("d0 flush_cnt",  {28'b0, fc0}, e.fc);
        chk("d0 retire_cnt", {28'b0, rc0}, e.rc);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1 stall_pc",   {31'b0, s1},  {31'b0, e.s});
        chk("d1 bubble_ex",  {31'b0, b1},  {31'b0, e.b});
        chk("d1 flush_id",   {31'b0, f1},  {31'b0, e.f});
        chk("d1 jump_taken", {31'b0, j1},  {31'b0, e.j});
        chk("d1 stall_cnt",  {24'b0, sc1}, e.sc);
        chk("d1 flush_cnt",  {24'b0, fc1}, e.fc);
        chk("d1 retire_cnt", {24'b0, rc1}, e.rc);
      end
    end
  end

  initial begin
    reset = 1'b1;
    rs1 = '0; rs2 = '0; rd = '0; u1 = 0; u2 = 0; wen = 0; jf = 0;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) m_pend[d][r] = 0;
      m_idv[d] = 0; m_exv[d] = 0; m_sc[d] = 0; m_fc[d] = 0; m_rc[d] = 0;
    end
    repeat (2) @(posedge clk);

    // Reset state, then independent ADDIs every cycle.
    for (int i = 1; i <= 7; i++) addi(i);

    // ADDI x5 followed by ADD x6,x5,x5 held in ID.
    addi(5);
    repeat (5) step(0, 5, 1, 5, 1, 6, 1, 0);
    repeat (3) addi(8);

    // One independent instruction between producer and consumer.
    addi(5);
    addi(7);
    repeat (4) step(0, 5, 1, 5, 1, 6, 1, 0);
    repeat (3) addi(8);

    // JAL x1 reaches EX and jumps while ID holds ADD x2,x1,x1.
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 1, 1, 1, 2, 1, 1);
    // jump_flag while EX holds the squashed bubble, then the target.
    step(0, 1, 1, 1, 1, 3, 1, 1);
    repeat (3) step(0, 1, 1, 1, 1, 3, 1, 0);

    // Producer writing x0 then consumer of x0.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 1, 0, 1, 9, 1, 0);

    // Reset in the middle of a stall.
    addi(5);
    repeat (2) step(0, 5, 1, 5, 1, 6, 1, 0);
    step(1, 5, 1, 5, 1, 6, 1, 0);
    repeat (4) step(0, 5, 1, 5, 1, 6, 1, 0);

    // Randomised traffic on a small register set so hazards are frequent;
    // long enough to saturate the narrow counters.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0),
           $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0));
    end

    @(negedge clk);
    #2;
    for (int k = 0; k < 10 && (q0.size() > 0 || q1.size() > 0); k++) @(negedge clk);
    #2;
    if (q0.size() > 0 || q1.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d entries left, required 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
